// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_if
// Brief    : Start/busy/done handshake and operand/result bundle for
//            serial_subtractor. ovf exists only with SERIAL_SUB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
`else
  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
`endif
endinterface
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial a - b - bin, LSB first, one bit per clock, WIDTH
//            cycles per operation. Optional signed overflow: SERIAL_SUB_OVF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  serial_subtractor_if.slave  bus
);
  localparam int              c_CW   = $clog2(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_br_nxt;

  // r_ar holds the unprocessed minuend bits at the bottom and the assembled
  // difference bits at the top, so one register serves as both.
  logic [WIDTH-1:0] r_ar;
  logic [WIDTH-1:0] r_b;
  logic             r_br;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_done;
`ifdef SERIAL_SUB_OVF_EN
  logic             r_amsb;
  logic             r_bmsb;
  logic             r_ovf;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == c_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_d      = r_ar[0] ^ r_b[0] ^ r_br;
    w_br_nxt = (~r_ar[0] & r_b[0]) | (~(r_ar[0] ^ r_b[0]) & r_br);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ar   <= '0;
      r_b    <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
      r_diff <= '0;
      r_bout <= 1'b0;
      r_done <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_ovf  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_ar   <= bus.a;
        r_b    <= bus.b;
        r_br   <= bus.bin;
        r_cnt  <= '0;
`ifdef SERIAL_SUB_OVF_EN
        r_amsb <= bus.a[WIDTH-1];
        r_bmsb <= bus.b[WIDTH-1];
`endif
      end else if (r_state == RUN) begin
        r_ar  <= {w_d, r_ar[WIDTH-1:1]};
        r_b   <= {1'b0, r_b[WIDTH-1:1]};
        r_br  <= w_br_nxt;
        r_cnt <= r_cnt + c_CW'(1);
        if (w_last) begin
          r_diff <= {w_d, r_ar[WIDTH-1:1]};
          r_bout <= w_br_nxt;
          r_done <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          // The final difference bit is the result MSB.
          r_ovf  <= (r_amsb ^ r_bmsb) & (w_d ^ r_amsb);
`endif
        end
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Self-checking scoreboard bench for serial_subtractor, WIDTH = 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;
  typedef struct packed {
    logic [3:0] diff;
    logic       bout;
    logic       ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  serial_subtractor_if #(.WIDTH(4)) bus();

  serial_subtractor #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
    exp_t       e;
    logic [4:0] r5;
    r5     = {1'b0, ta} - {1'b0, tb} - {4'b0000, tbin};
    e.diff = r5[3:0];
    e.bout = r5[4];
    e.ovf  = (ta[3] ^ tb[3]) & (r5[3] ^ ta[3]);
    return e;
  endfunction

  // Called at a negedge with the DUT able to accept; returns one negedge later.
  task automatic launch(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
    bus.a     = ta;
    bus.b     = tb;
    bus.bin   = tbin;
    bus.start = 1'b1;
    sb.push_back(model(ta, tb, tbin));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit timeout, output int cycles);
    bit found = 1'b0;
    int i = 0;
    cycles = 0;
    while (!found && i < 20) begin
      @(negedge clk);
      i++;
      if (bus.done === 1'b1) begin
        found  = 1'b1;
        cycles = i;
      end
    end
    timeout = !found;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.busy, bus.done, bus.bout, bus.diff} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy/done/bout/diff=%b required 0000000",
               {bus.busy, bus.done, bus.bout, bus.diff});
    end
`ifdef SERIAL_SUB_OVF_EN
    n_vec++;
    if (bus.ovf !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ovf: got %b required 0", bus.ovf);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_basic();
    logic [3:0] va [3] = '{4'b0110, 4'b0010, 4'b0000};
    logic [3:0] vb [3] = '{4'b0101, 4'b1101, 4'b0000};
    logic       vc [3] = '{1'b0, 1'b0, 1'b1};
    bit   to;
    int   cyc;
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      launch(va[k], vb[k], vc[k]);
      n_vec++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_err++;
        $display("FAIL basic_busy[%0d]: got busy=%b done=%b required 1 0", k, bus.busy, bus.done);
      end
      wait_done(to, cyc);
      e = sb.pop_front();
      n_vec++;
      if (to || cyc != 4) begin
        n_err++;
        $display("FAIL basic_latency[%0d]: got %0d cycles (timeout=%0d) required 4", k, cyc, to);
      end
      n_vec++;
      if ({bus.bout, bus.diff} !== {e.bout, e.diff} || bus.busy !== 1'b0) begin
        n_err++;
        $display("FAIL basic_result[%0d]: got bout,diff=%b busy=%b required %b busy=0",
                 k, {bus.bout, bus.diff}, bus.busy, {e.bout, e.diff});
      end
      @(negedge clk);
    end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic [3:0] va [2] = '{4'b0111, 4'b0110};
    logic [3:0] vb [2] = '{4'b1000, 4'b0101};
    logic       vo [2] = '{1'b1, 1'b0};
    bit to;
    int cyc;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      launch(va[k], vb[k], 1'b0);
      wait_done(to, cyc);
      e = sb.pop_front();
      n_vec++;
      if (to || {bus.ovf, bus.bout, bus.diff} !== {vo[k], e.bout, e.diff}) begin
        n_err++;
        $display("FAIL ovf[%0d]: got ovf,bout,diff=%b required %b (timeout=%0d)",
                 k, {bus.ovf, bus.bout, bus.diff}, {vo[k], e.bout, e.diff}, to);
      end
      @(negedge clk);
    end
  endtask
`endif

  task automatic test_ignore_start();
    int         dones = 0;
    int         first = 0;
    logic [4:0] got   = '0;
    exp_t       e;
    launch(4'b1001, 4'b0011, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      if (k <= 3) begin
        bus.start = 1'b1;
        bus.a     = 4'($urandom);
        bus.b     = 4'($urandom);
        bus.bin   = 1'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      if (bus.done === 1'b1) begin
        dones++;
        if (first == 0) begin
          first = k;
          got   = {bus.bout, bus.diff};
        end
      end
    end
    e = sb.pop_front();
    n_vec++;
    if (dones != 1 || first != 4) begin
      n_err++;
      $display("FAIL ignore_done_count: got %0d pulses first at %0d required 1 at 4", dones, first);
    end
    n_vec++;
    if (got !== {e.bout, e.diff}) begin
      n_err++;
      $display("FAIL ignore_result: got %b required %b", got, {e.bout, e.diff});
    end
  endtask

  task automatic test_back_to_back();
    bit   to;
    int   cyc;
    exp_t e;
    bus.a = 4'b0101; bus.b = 4'b0111; bus.bin = 1'b1; bus.start = 1'b1;
    sb.push_back(model(4'b0101, 4'b0111, 1'b1));
    @(negedge clk);
    bus.a = 4'b1111; bus.b = 4'b0001; bus.bin = 1'b0;
    sb.push_back(model(4'b1111, 4'b0001, 1'b0));
    wait_done(to, cyc);
    e = sb.pop_front();
    n_vec++;
    if (to || cyc != 4 || {bus.bout, bus.diff} !== {e.bout, e.diff}) begin
      n_err++;
      $display("FAIL b2b_first: got %b after %0d cycles required %b after 4",
               {bus.bout, bus.diff}, cyc, {e.bout, e.diff});
    end
    @(negedge clk);
    bus.start = 1'b0;
    n_vec++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_no_gap: got busy=%b done=%b required 1 0", bus.busy, bus.done);
    end
    wait_done(to, cyc);
    e = sb.pop_front();
    n_vec++;
    if (to || cyc != 4 || {bus.bout, bus.diff} !== {e.bout, e.diff}) begin
      n_err++;
      $display("FAIL b2b_second: got %b after %0d cycles required %b after 4",
               {bus.bout, bus.diff}, cyc, {e.bout, e.diff});
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    bit   to;
    int   cyc;
    int   dones = 0;
    exp_t e;
    launch(4'b1100, 4'b0001, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    e = sb.pop_back();
    n_vec++;
    if ({bus.busy, bus.done, bus.bout, bus.diff} !== 7'b0) begin
      n_err++;
      $display("FAIL abort_outputs: got busy/done/bout/diff=%b required 0000000",
               {bus.busy, bus.done, bus.bout, bus.diff});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    n_vec++;
    if (dones != 0) begin
      n_err++;
      $display("FAIL abort_no_done: got %0d pulses required 0", dones);
    end
    launch(4'b1011, 4'b0110, 1'b1);
    wait_done(to, cyc);
    e = sb.pop_front();
    n_vec++;
    if (to || {bus.bout, bus.diff} !== {e.bout, e.diff}) begin
      n_err++;
      $display("FAIL abort_recover: got %b required %b (timeout=%0d)", {bus.bout, bus.diff},
               {e.bout, e.diff}, to);
    end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    bit   to;
    int   cyc;
    exp_t e;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          launch(4'(ia), 4'(ib), 1'(ic));
          wait_done(to, cyc);
          e = sb.pop_front();
          n_vec++;
          if (to || cyc != 4 || {bus.bout, bus.diff} !== {e.bout, e.diff}) begin
            n_err++;
            $display("FAIL sweep a=%0d b=%0d bin=%0d: got %b in %0d cycles required %b in 4",
                     ia, ib, ic, {bus.bout, bus.diff}, cyc, {e.bout, e.diff});
          end
`ifdef SERIAL_SUB_OVF_EN
          n_vec++;
          if (bus.ovf !== e.ovf) begin
            n_err++;
            $display("FAIL sweep_ovf a=%0d b=%0d bin=%0d: got %b required %b",
                     ia, ib, ic, bus.ovf, e.ovf);
          end
`endif
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_sweep();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover entries required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
